ext_mem_master_lane: RTL and testbench
======================================

Name: ext_mem_master_lane

Overview:
Synthesizable initiator for one lane of the off-chip memory bus (oe/we/addr/Wdata/data_ram_size out; Rdata/DataRdy in).
- Accepts read/write commands on a valid/ready port and drives the bus until the responder asserts DataRdy.
- Returns read data or write completion on a response port.
- Lets accelerator-side logic and standalone benches drive the external memory model with the same protocol the HLS-generated main uses; multi-lane masters instantiate one per lane.

Parameters:
ADDR_W, 10, lane address width
DATA_W, 8, lane data width
SIZE_W, 4, width of data_ram_size field (access size in bits)
TIMEOUT, 255, max cycles waiting for DataRdy before aborting; 0 disables timeout
CNT_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at posedge
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_size  in  SIZE_W  access size in bits
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at posedge
rsp_rdata  out  DATA_W  masked read data; 0 for writes and errors
rsp_err  out  1  1 = timeout abort
Mout_oe_ram  out  1  read enable
Mout_we_ram  out  1  write enable
Mout_addr_ram  out  ADDR_W  address
Mout_Wdata_ram  out  DATA_W  write data
Mout_data_ram_size  out  SIZE_W  access size
M_Rdata_ram  in  DATA_W  read data from responder
M_DataRdy  in  1  transfer complete

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; cmd_ready=0 while reset is low, 1 from the first cycle after release.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - All Mout_* = 0; timeout counter = 0.
  - Reset mid-transaction abandons it with no response.
- FSM states:
  - IDLE: cmd_ready=1. On accept, register we/addr/size/wdata and go to ISSUE.
  - ISSUE: Mout_oe_ram=~we, Mout_we_ram=we; addr/Wdata/size driven from registers and held stable.
    - Mout_Wdata_ram = wdata & mask. Mout_Wdata_ram=0 for reads.
    - At posedge with M_DataRdy=1: capture rdata = M_Rdata_ram & mask (0 for writes), clear oe/we, go to RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err stable until handshake, then go to IDLE.
- Size mask: mask = size >= DATA_W ? all-ones : (1<<size)-1. size=0 gives mask 0: the write is a no-op at the responder; a read returns 0. The transaction still completes.
- Latency:
  - Accept at edge N → oe/we high during cycle N+1.
  - DataRdy sampled high at edge M → oe/we low and rsp_valid high from M.
  - Back-to-back rate is one command per (bus latency + 2) cycles; there is no pipelining.
- Bus rules:
  - Mout_oe_ram and Mout_we_ram are never both 1.
  - Both are 0 outside ISSUE.
  - M_DataRdy is ignored outside ISSUE. A spurious DataRdy in IDLE/RESP has no effect.
  - DataRdy in the first ISSUE cycle (combinational responder) is legal and completes the transaction.
- Timeout:
  - Counter clears on entering ISSUE and increments each ISSUE cycle without DataRdy.
  - Reaching TIMEOUT → clear oe/we, rsp_err=1, rsp_rdata=0, go to RESP.
  - DataRdy on the same edge as expiry wins: normal completion, err=0.
- cmd_ready is low in ISSUE and RESP. cmd_valid held there is neither accepted nor lost; it is taken on return to IDLE.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs stable.

Decomposition:
- Shared package ext_mem_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - lane width constants (ADDR_W=10, DATA_W=8, SIZE_W=4);
  - the size-to-mask function (reused by the responder model and the future multi-lane wrapper).
- No sub-module; the timeout counter stays inline.
- The two-lane master ext_mem_master is later built as two instances of this block.

Test Plan:
- Responder with 2-cycle read delay. Write addr=0x10, size=8, wdata=0xA5, then read addr=0x10, size=8. Required: write rsp_err=0, rsp_rdata=0; read rsp_rdata=0xA5; oe and we never both high.
- Write 0xFF size=8, then write 0x00 size=4 to the same addr, then read size=8. Required: rsp_rdata=0xF0. Also read size=4 with memory 0xF0 → rsp_rdata=0x00.
- Responder never asserts DataRdy, TIMEOUT=5. Required: after 5 ISSUE cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0; Mout_oe_ram=0 in the RESP cycle.
- Hold rsp_ready=0 for 10 cycles after a read of 0x3C. Required: rsp_valid stays 1 and rsp_rdata stays 0x3C; cmd_ready stays 0; a queued cmd_valid is accepted the cycle after the handshake.
- Pulse DataRdy while IDLE, and assert reset=0 mid-ISSUE. Required: no rsp_valid from the spurious pulse; on reset all Mout_* and rsp_valid go to 0 immediately without waiting for clock; cmd_ready=1 the cycle after reset release.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared definitions for the off-chip memory bus lane master.
// Holds the lane state encoding, the default lane widths and the helper
// that turns an access size in bits into a data mask.  The helper is
// shared by the lane master, responder models and multi-lane wrappers.
package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } lane_state_e;

    localparam int LANE_ADDR_W = 10;
    localparam int LANE_DATA_W = 8;
    localparam int LANE_SIZE_W = 4;

    // Widest lane the mask helper supports; callers truncate to their width.
    localparam int MASK_MAX_W  = 64;

    // Mask with the low 'size' bits set, saturating at data_w bits.
    // size = 0 yields an all-zero mask.
    function automatic logic [MASK_MAX_W-1:0] size_mask(
        input int unsigned size,
        input int unsigned data_w
    );
        logic [MASK_MAX_W-1:0] m;
        m = {MASK_MAX_W{1'b0}};
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            m[i] = (i < size) && (i < data_w);
        end
        return m;
    endfunction

endpackage

// File: rtl/ext_mem_master_lane.sv
// Single-lane initiator for the off-chip memory bus.
// Takes read/write commands on a valid/ready port, drives oe/we/addr/
// Wdata/size until the responder raises DataRdy (or the wait times out),
// then presents the result on a valid/ready response port.
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_we/addr/size/wdata payload
//   rsp_valid/rsp_ready     response handshake; rsp_rdata (masked), rsp_err
//   Mout_*                  bus outputs toward the responder (all registered)
//   M_Rdata_ram, M_DataRdy  responder read data and completion strobe
module ext_mem_master_lane
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W  = LANE_ADDR_W,
    parameter int DATA_W  = LANE_DATA_W,
    parameter int SIZE_W  = LANE_SIZE_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SIZE_W-1:0] cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    lane_state_e       state_r, state_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [SIZE_W-1:0] size_r, size_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              oe_out_r, oe_out_s;
    logic              we_out_r, we_out_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              rsp_err_r, rsp_err_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [DATA_W-1:0] cmd_mask_s;
    logic [DATA_W-1:0] issue_mask_s;

    // Masks for the incoming command and for the transaction in flight.
    always_comb begin
        cmd_mask_s   = DATA_W'(size_mask(32'(cmd_size), DATA_W));
        issue_mask_s = DATA_W'(size_mask(32'(size_r), DATA_W));
        cnt_inc_s    = cnt_r + CNT_ONE;
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s     = state_r;
        we_s        = we_r;
        addr_s      = addr_r;
        size_s      = size_r;
        wdata_s     = wdata_r;
        oe_out_s    = oe_out_r;
        we_out_s    = we_out_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        cnt_s       = cnt_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    state_s  = ISSUE;
                    we_s     = cmd_we;
                    addr_s   = cmd_addr;
                    size_s   = cmd_size;
                    // Reads drive zero on the write data bus.
                    wdata_s  = cmd_we ? (cmd_wdata & cmd_mask_s) : {DATA_W{1'b0}};
                    oe_out_s = ~cmd_we;
                    we_out_s = cmd_we;
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                // DataRdy beats a timeout expiring on the same edge.
                if (M_DataRdy) begin
                    state_s     = RESP;
                    oe_out_s    = 1'b0;
                    we_out_s    = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = we_r ? {DATA_W{1'b0}} : (M_Rdata_ram & issue_mask_s);
                end else if (TIMEOUT_EN && (cnt_inc_s == TIMEOUT_C)) begin
                    state_s     = RESP;
                    oe_out_s    = 1'b0;
                    we_out_s    = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                    cnt_s       = cnt_inc_s;
                end else begin
                    cnt_s       = cnt_inc_s;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = {DATA_W{1'b0}};
                end else begin
                    state_s     = RESP;
                end
            end
            default: begin
                state_s     = IDLE;
                oe_out_s    = 1'b0;
                we_out_s    = 1'b0;
                rsp_valid_s = 1'b0;
                rsp_err_s   = 1'b0;
                rsp_rdata_s = {DATA_W{1'b0}};
                cnt_s       = {CNT_W{1'b0}};
            end
        endcase
        // Registered ready: low during reset, high one cycle after release.
        cmd_ready_s = (state_s == IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            size_r      <= {SIZE_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            oe_out_r    <= 1'b0;
            we_out_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            size_r      <= size_s;
            wdata_r     <= wdata_s;
            oe_out_r    <= oe_out_s;
            we_out_r    <= we_out_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            cnt_r       <= cnt_s;
        end
    end

    assign cmd_ready          = cmd_ready_r;
    assign rsp_valid          = rsp_valid_r;
    assign rsp_rdata          = rsp_rdata_r;
    assign rsp_err            = rsp_err_r;
    assign Mout_oe_ram        = oe_out_r;
    assign Mout_we_ram        = we_out_r;
    assign Mout_addr_ram      = addr_r;
    assign Mout_Wdata_ram     = wdata_r;
    assign Mout_data_ram_size = size_r;

endmodule

// File: tb/tb_ext_mem_master_lane.sv
// Directed self-checking bench for ext_mem_master_lane (TIMEOUT = 5).
// A small responder model with a byte memory is driven from the same
// initial block; inputs change on the falling edge, outputs are checked
// on the falling edge as well.
module tb_ext_mem_master_lane;
    import ext_mem_pkg::*;

    localparam int TO = 5;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [9:0] cmd_addr;
    logic [3:0] cmd_size;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       Mout_oe_ram;
    logic       Mout_we_ram;
    logic [9:0] Mout_addr_ram;
    logic [7:0] Mout_Wdata_ram;
    logic [3:0] Mout_data_ram_size;
    logic [7:0] M_Rdata_ram;
    logic       M_DataRdy;

    logic [7:0] mem [0:1023];
    int vectors;
    int miscompares;

    ext_mem_master_lane #(
        .ADDR_W (10),
        .DATA_W (8),
        .SIZE_W (4),
        .TIMEOUT(TO),
        .CNT_W  (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_we            (cmd_we),
        .cmd_addr          (cmd_addr),
        .cmd_size          (cmd_size),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .Mout_oe_ram       (Mout_oe_ram),
        .Mout_we_ram       (Mout_we_ram),
        .Mout_addr_ram     (Mout_addr_ram),
        .Mout_Wdata_ram    (Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram       (M_Rdata_ram),
        .M_DataRdy         (M_DataRdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Present a command at a falling edge; it is accepted on the next rising edge.
    task automatic send_cmd(input logic we, input logic [9:0] addr,
                            input logic [3:0] size, input logic [7:0] wdata);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Responder: DataRdy on the delay-th ISSUE cycle (0 = never, run TO cycles).
    task automatic serve(input int delay, input logic exp_oe, input logic [9:0] exp_addr,
                         input logic [3:0] exp_size, input logic [7:0] exp_wd);
        int n;
        logic exp_we;
        logic [7:0] m;
        exp_we = ~exp_oe;
        n = (delay == 0) ? TO : delay;
        for (int i = 1; i <= n; i++) begin
            chk("issue_oe", 32'(Mout_oe_ram), 32'(exp_oe));
            chk("issue_we", 32'(Mout_we_ram), 32'(exp_we));
            chk("oe_we_excl", 32'(Mout_oe_ram & Mout_we_ram), 32'd0);
            chk("issue_addr", 32'(Mout_addr_ram), 32'(exp_addr));
            chk("issue_size", 32'(Mout_data_ram_size), 32'(exp_size));
            chk("issue_wdata", 32'(Mout_Wdata_ram), 32'(exp_wd));
            chk("issue_no_rsp", 32'(rsp_valid), 32'd0);
            chk("issue_not_ready", 32'(cmd_ready), 32'd0);
            if (i == delay) begin
                M_DataRdy   = 1'b1;
                M_Rdata_ram = mem[Mout_addr_ram];
                if (Mout_we_ram) begin
                    m = 8'(size_mask(32'(Mout_data_ram_size), 8));
                    mem[Mout_addr_ram] = (mem[Mout_addr_ram] & ~m) | (Mout_Wdata_ram & m);
                end
            end
            @(posedge clock);
            @(negedge clock);
            M_DataRdy   = 1'b0;
            M_Rdata_ram = 8'h00;
        end
    endtask

    task automatic check_rsp(input logic [7:0] exp_rdata, input logic exp_err);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_oe_low", 32'(Mout_oe_ram), 32'd0);
        chk("rsp_we_low", 32'(Mout_we_ram), 32'd0);
        chk("rsp_not_ready", 32'(cmd_ready), 32'd0);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("ack_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("ack_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = 10'h000;
        cmd_size    = 4'd0;
        cmd_wdata   = 8'h00;
        rsp_ready   = 1'b0;
        M_Rdata_ram = 8'h00;
        M_DataRdy   = 1'b0;

        // Reset state
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_oe", 32'(Mout_oe_ram), 32'd0);
        chk("rst_we", 32'(Mout_we_ram), 32'd0);
        chk("rst_addr", 32'(Mout_addr_ram), 32'd0);
        chk("rst_wdata", 32'(Mout_Wdata_ram), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        chk("release_not_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        chk("release_ready", 32'(cmd_ready), 32'd1);

        // Write 0xA5 then read it back, 2-cycle responder
        send_cmd(1'b1, 10'h010, 4'd8, 8'hA5);
        serve(2, 1'b0, 10'h010, 4'd8, 8'hA5);
        check_rsp(8'h00, 1'b0);
        ack();
        send_cmd(1'b0, 10'h010, 4'd8, 8'h00);
        serve(2, 1'b1, 10'h010, 4'd8, 8'h00);
        check_rsp(8'hA5, 1'b0);
        ack();

        // Partial-width write: 0xFF then 0x00 size 4 -> 0xF0
        send_cmd(1'b1, 10'h020, 4'd8, 8'hFF);
        serve(1, 1'b0, 10'h020, 4'd8, 8'hFF);
        check_rsp(8'h00, 1'b0);
        ack();
        send_cmd(1'b1, 10'h020, 4'd4, 8'h00);
        serve(3, 1'b0, 10'h020, 4'd4, 8'h00);
        check_rsp(8'h00, 1'b0);
        ack();
        send_cmd(1'b0, 10'h020, 4'd8, 8'h00);
        serve(2, 1'b1, 10'h020, 4'd8, 8'h00);
        check_rsp(8'hF0, 1'b0);
        ack();
        send_cmd(1'b0, 10'h020, 4'd4, 8'h00);
        serve(2, 1'b1, 10'h020, 4'd4, 8'h00);
        check_rsp(8'h00, 1'b0);
        ack();

        // size 0 write drives zero data; size 12 saturates to full width
        send_cmd(1'b1, 10'h021, 4'd0, 8'h77);
        serve(2, 1'b0, 10'h021, 4'd0, 8'h00);
        check_rsp(8'h00, 1'b0);
        ack();
        send_cmd(1'b1, 10'h030, 4'd12, 8'h3C);
        serve(2, 1'b0, 10'h030, 4'd12, 8'h3C);
        check_rsp(8'h00, 1'b0);
        ack();

        // Timeout: no DataRdy for 5 ISSUE cycles
        send_cmd(1'b0, 10'h040, 4'd8, 8'h00);
        serve(0, 1'b1, 10'h040, 4'd8, 8'h00);
        check_rsp(8'h00, 1'b1);
        ack();

        // DataRdy on the expiry edge completes normally
        send_cmd(1'b0, 10'h020, 4'd8, 8'h00);
        serve(TO, 1'b1, 10'h020, 4'd8, 8'h00);
        check_rsp(8'hF0, 1'b0);
        ack();

        // Backpressure with a queued command
        send_cmd(1'b0, 10'h030, 4'd8, 8'h00);
        serve(2, 1'b1, 10'h030, 4'd8, 8'h00);
        check_rsp(8'h3C, 1'b0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 10'h050;
        cmd_size  = 4'd8;
        cmd_wdata = 8'h99;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h3C);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_bus_idle", 32'(Mout_oe_ram | Mout_we_ram), 32'd0);
            @(posedge clock);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
        chk("bp_queued_ready", 32'(cmd_ready), 32'd1);
        chk("bp_not_issued_yet", 32'(Mout_we_ram), 32'd0);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        serve(2, 1'b0, 10'h050, 4'd8, 8'h99);
        check_rsp(8'h00, 1'b0);
        ack();
        send_cmd(1'b0, 10'h050, 4'd8, 8'h00);
        serve(1, 1'b1, 10'h050, 4'd8, 8'h00);
        check_rsp(8'h99, 1'b0);
        ack();

        // Spurious DataRdy in IDLE
        M_DataRdy   = 1'b1;
        M_Rdata_ram = 8'hEE;
        @(posedge clock);
        @(negedge clock);
        M_DataRdy   = 1'b0;
        M_Rdata_ram = 8'h00;
        chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
        chk("spurious_ready", 32'(cmd_ready), 32'd1);
        chk("spurious_bus_idle", 32'(Mout_oe_ram | Mout_we_ram), 32'd0);

        // Reset mid-ISSUE clears outputs without a clock edge
        send_cmd(1'b0, 10'h010, 4'd8, 8'h00);
        chk("pre_reset_oe", 32'(Mout_oe_ram), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_oe", 32'(Mout_oe_ram), 32'd0);
        chk("midrst_we", 32'(Mout_we_ram), 32'd0);
        chk("midrst_addr", 32'(Mout_addr_ram), 32'd0);
        chk("midrst_size", 32'(Mout_data_ram_size), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("rerelease_not_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        chk("rerelease_ready", 32'(cmd_ready), 32'd1);
        chk("rerelease_no_rsp", 32'(rsp_valid), 32'd0);

        // Lane works again after reset
        send_cmd(1'b0, 10'h010, 4'd8, 8'h00);
        serve(1, 1'b1, 10'h010, 4'd8, 8'h00);
        check_rsp(8'hA5, 1'b0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
